// File: rtl/captura_matriz.sv
// captura_matriz: samples a multiplexed 5x7 LED-matrix scan and rebuilds the column maps.
// Optional watchdog output sem_sinal is built only when CAPTURA_TIMEOUT_EN is defined.
module captura_matriz #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter int COL_ACTIVE_LOW = 1,
  parameter int ROW_ACTIVE_LOW = 1,
  parameter int TIMEOUT        = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] linhas,
  input  logic [4:0] colunas,
  output logic [6:0] mapa0,
  output logic [6:0] mapa1,
  output logic [6:0] mapa2,
  output logic [6:0] mapa3,
  output logic [6:0] mapa4,
  output logic       quadro_valido,
  output logic       erro_coluna,
  output logic       erro_sequencia,
  output logic [2:0] coluna_atual
`ifdef CAPTURA_TIMEOUT_EN
  ,
  output logic       sem_sinal
`endif
);

  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || STABLE_CYCLES > 255 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_err
    $error("captura_matriz: parameter out of range");
  end

  localparam logic [4:0]  COL_IDLE = (COL_ACTIVE_LOW != 0) ? 5'h1F : 5'h00;
  localparam logic [6:0]  ROW_IDLE = (ROW_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [11:0] PIN_IDLE = {ROW_IDLE, COL_IDLE};
  localparam logic [7:0]  STABLE_W = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  logic [11:0] sync_q [SYNC_STAGES];
  logic [4:0]  sel;
  logic [6:0]  row;
  logic [2:0]  n_set, col_idx;
  logic        is_single, is_multi, stable;

  state_t      state_q, state_d;
  logic [4:0]  cap_sel_q, cap_sel_d, prev_sel_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  exp_q, exp_d, coluna_q, coluna_d;
  logic        commit_q, commit_d, qv_q, ec_q, ec_d, es_q, es_d;
  logic        do_single, do_multi, shadow_we;
  logic [6:0]  shadow_q [5];
  logic [6:0]  mapa_q [5];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_IDLE;
    end else begin
      sync_q[0] <= {linhas, colunas};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Everything downstream of the synchronizer works in active-high terms.
  assign sel = (COL_ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1][4:0]  : sync_q[SYNC_STAGES-1][4:0];
  assign row = (ROW_ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1][11:5] : sync_q[SYNC_STAGES-1][11:5];

  always_comb begin
    n_set   = 3'd0;
    col_idx = 3'd0;
    for (int j = 0; j < 5; j++) begin
      if (sel[j]) begin
        n_set   = n_set + 3'd1;
        col_idx = 3'(j);
      end
    end
  end

  assign is_single = (n_set == 3'd1);
  assign is_multi  = (n_set > 3'd1);

  // Run length of the current sel pattern, including this cycle.
  assign cnt_d  = (sel != prev_sel_q) ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
  assign stable = (cnt_d >= STABLE_W);

  always_comb begin
    state_d   = state_q;
    cap_sel_d = cap_sel_q;
    do_single = 1'b0;
    do_multi  = 1'b0;
    case (state_q)
      IDLE:     state_d = SETTLE;
      SETTLE: begin
        if (stable && is_single) begin
          do_single = 1'b1;
          cap_sel_d = sel;
          state_d   = CAPTURED;
        end else if (stable && is_multi) begin
          do_multi  = 1'b1;
          cap_sel_d = sel;
          state_d   = CAPTURED;
        end
      end
      CAPTURED: if (sel != cap_sel_q) state_d = SETTLE;
      default:  state_d = IDLE;
    endcase
    if (!enable) begin
      state_d   = IDLE;
      do_single = 1'b0;
      do_multi  = 1'b0;
    end
  end

  always_comb begin
    exp_d     = exp_q;
    coluna_d  = coluna_q;
    shadow_we = 1'b0;
    commit_d  = 1'b0;
    ec_d      = do_multi;
    es_d      = 1'b0;
    if (state_q == IDLE || !enable || do_multi) begin
      exp_d = 3'd0;
    end else if (do_single) begin
      coluna_d = col_idx;
      if (col_idx == 3'd0) begin
        shadow_we = 1'b1;
        exp_d     = 3'd1;
      end else if (col_idx == exp_q) begin
        shadow_we = 1'b1;
        if (col_idx == 3'd4) begin
          exp_d    = 3'd0;
          commit_d = 1'b1;
        end else begin
          exp_d = exp_q + 3'd1;
        end
      end else begin
        es_d  = 1'b1;
        exp_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cap_sel_q  <= 5'd0;
      prev_sel_q <= 5'd0;
      cnt_q      <= 8'd0;
      exp_q      <= 3'd0;
      coluna_q   <= 3'd0;
      commit_q   <= 1'b0;
      qv_q       <= 1'b0;
      ec_q       <= 1'b0;
      es_q       <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= 7'd0;
        mapa_q[i]   <= 7'd0;
      end
    end else begin
      state_q    <= state_d;
      cap_sel_q  <= cap_sel_d;
      prev_sel_q <= sel;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      coluna_q   <= coluna_d;
      commit_q   <= commit_d;
      qv_q       <= commit_q;
      ec_q       <= ec_d;
      es_q       <= es_d;
      if (shadow_we) shadow_q[col_idx] <= row;
      // Commit lands one edge after the column-4 capture, together with the pulse.
      if (commit_q) begin
        for (int i = 0; i < 5; i++) mapa_q[i] <= shadow_q[i];
      end
    end
  end

  assign mapa0          = mapa_q[0];
  assign mapa1          = mapa_q[1];
  assign mapa2          = mapa_q[2];
  assign mapa3          = mapa_q[3];
  assign mapa4          = mapa_q[4];
  assign quadro_valido  = qv_q;
  assign erro_coluna    = ec_q;
  assign erro_sequencia = es_q;
  assign coluna_atual   = coluna_q;

`ifdef CAPTURA_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  logic [15:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (!enable || do_single) wd_d = 16'd0;
    else if (wd_q < TIMEOUT_W) wd_d = wd_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wd_q <= 16'd0;
    else       wd_q <= wd_d;
  end

  assign sem_sinal = enable && (wd_q >= TIMEOUT_W);
`endif

endmodule

// File: tb/tb_captura_matriz.sv
// Randomized bench for captura_matriz; a frame-level model predicts maps, pulse counts and coluna_atual.
module tb_captura_matriz;
  localparam int STABLE = 4;

  logic       clock = 1'b0;
  logic       reset, enable;
  logic [6:0] linhas;
  logic [4:0] colunas;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic       quadro_valido, erro_coluna, erro_sequencia;
  logic [2:0] coluna_atual;
`ifdef CAPTURA_TIMEOUT_EN
  logic       sem_sinal;
`endif

  captura_matriz #(
    .SYNC_STAGES(2), .STABLE_CYCLES(STABLE), .COL_ACTIVE_LOW(1), .ROW_ACTIVE_LOW(1)
`ifdef CAPTURA_TIMEOUT_EN
    , .TIMEOUT(100)
`endif
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .linhas(linhas), .colunas(colunas),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .quadro_valido(quadro_valido), .erro_coluna(erro_coluna), .erro_sequencia(erro_sequencia),
    .coluna_atual(coluna_atual)
`ifdef CAPTURA_TIMEOUT_EN
    , .sem_sinal(sem_sinal)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;
  int cnt_qv = 0, cnt_ec = 0, cnt_es = 0;

  // Expected state, derived from the frame/sequence rules only.
  logic [6:0] m_map [5];
  logic [6:0] m_sh  [5];
  int m_exp, m_col, m_qv, m_ec, m_es;

  always @(negedge clock) begin
    if (!reset) begin
      if (quadro_valido)  cnt_qv++;
      if (erro_coluna)    cnt_ec++;
      if (erro_sequencia) cnt_es++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int j = 0; j < 5; j++) begin
      m_map[j] = 7'd0;
      m_sh[j]  = 7'd0;
    end
    m_exp = 0;
    m_col = 0;
  endtask

  task automatic model_capture(input logic [4:0] sel, input logic [6:0] rows, input int hold);
    int k;
    if (hold < STABLE || sel == 5'd0 || !enable) return;
    if ($countones(sel) > 1) begin
      m_ec++;
      m_exp = 0;
      return;
    end
    k = 0;
    for (int j = 0; j < 5; j++) if (sel[j]) k = j;
    m_col = k;
    if (k == 0) begin
      m_sh[0] = rows;
      m_exp = 1;
    end else if (k == m_exp) begin
      m_sh[k] = rows;
      m_exp++;
      if (k == 4) begin
        m_map = m_sh;
        m_qv++;
        m_exp = 0;
      end
    end else begin
      m_es++;
      m_exp = 0;
    end
  endtask

  // Drive one column pattern (active-high sel / lit rows) for hold cycles, then a blank gap.
  task automatic seg(input logic [4:0] sel, input logic [6:0] rows, input int hold, input int gap);
    colunas = ~sel;
    linhas  = ~rows;
    repeat (hold) step();
    model_capture(sel, rows, hold);
    colunas = 5'h1F;
    linhas  = 7'h7F;
    repeat (gap) step();
  endtask

  task automatic verify(input string name);
    logic [6:0] mp [5];
    repeat (8) step();
    mp = '{mapa0, mapa1, mapa2, mapa3, mapa4};
    check({name, "_qv"}, cnt_qv, m_qv);
    check({name, "_ec"}, cnt_ec, m_ec);
    check({name, "_es"}, cnt_es, m_es);
    for (int j = 0; j < 5; j++) check($sformatf("%s_mapa%0d", name, j), 32'(mp[j]), 32'(m_map[j]));
    check({name, "_coluna"}, 32'(coluna_atual), m_col);
    $display("verify %s: frames=%0d col_err=%0d seq_err=%0d coluna=%0d map=%h_%h_%h_%h_%h",
             name, cnt_qv, cnt_ec, cnt_es, coluna_atual, mapa0, mapa1, mapa2, mapa3, mapa4);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_mapa0"}, 32'(mapa0), 0);
    check({name, "_mapa1"}, 32'(mapa1), 0);
    check({name, "_mapa2"}, 32'(mapa2), 0);
    check({name, "_mapa3"}, 32'(mapa3), 0);
    check({name, "_mapa4"}, 32'(mapa4), 0);
    check({name, "_pulses"}, {29'd0, quadro_valido, erro_coluna, erro_sequencia}, 0);
    check({name, "_coluna"}, 32'(coluna_atual), 0);
  endtask

  task automatic clean_frame(input int rnd);
    for (int j = 0; j < 5; j++)
      seg(5'(1 << j), (rnd != 0) ? 7'($urandom) : 7'(1 << j),
          (rnd != 0) ? int'($urandom_range(6, 20)) : 20, (rnd != 0) ? int'($urandom_range(1, 3)) : 2);
  endtask

  initial begin
    m_qv = 0; m_ec = 0; m_es = 0;
    model_reset();
    reset = 1'b1; enable = 1'b0; colunas = 5'h1F; linhas = 7'h7F;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0; enable = 1'b1;
    step();

    clean_frame(0);
    verify("frame1");
    check("frame1_mapa4_const", 32'(mapa4), 32'h10);

    for (int j = 0; j < 5; j++) seg(5'(1 << j), 7'h7F, 20, 2);
    verify("all_lit");
    check("all_lit_mapa2_const", 32'(mapa2), 32'h7F);

    seg(5'b00001, 7'h11, 20, 2);
    seg(5'b00010, 7'h22, 20, 2);
    seg(5'b01000, 7'h33, 20, 2);
    verify("skip_col2");
    clean_frame(1);
    verify("after_skip");

    seg(5'b00001, 7'h05, 20, 2);
    seg(5'b00011, 7'h00, 10, 2);
    for (int j = 2; j < 5; j++) seg(5'(1 << j), 7'h3C, 20, 2);
    verify("multi_col");
    clean_frame(1);
    verify("after_multi");

    // Short glitch to another column before the column settles.
    seg(5'b00001, 7'h41, 2, 0);
    seg(5'b01000, 7'h12, 3, 0);
    seg(5'b00001, 7'h41, 20, 2);
    for (int j = 1; j < 5; j++) seg(5'(1 << j), 7'(7'h41 + j), 20, 2);
    verify("glitch");

    for (int j = 0; j < 3; j++) seg(5'(1 << j), 7'h2A, 20, 2);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check_all_zero("async_reset");
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    step();
    verify("after_reset");

    for (int j = 0; j < 3; j++) seg(5'(1 << j), 7'h55, 20, 2);
    enable = 1'b0;
    repeat (5) step();
    m_exp = 0;
    enable = 1'b1;
    step();
    seg(5'b01000, 7'h55, 20, 2);
    seg(5'b10000, 7'h55, 20, 2);
    verify("enable_drop");
    clean_frame(1);
    verify("after_enable");

    for (int b = 0; b < 16; b++) begin
      int kind, pos, a, c;
      kind = $urandom_range(0, 3);
      pos  = $urandom_range(1, 4);
      case (kind)
        0: clean_frame(1);
        1: repeat (5)
             seg(5'(1 << $urandom_range(0, 4)), 7'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(6, 16)),
                 $urandom_range(1, 3));
        2: for (int j = 0; j < 5; j++) begin
             if (j == pos) begin
               a = $urandom_range(0, 4);
               c = (a + 1 + $urandom_range(0, 3)) % 5;
               seg(5'(1 << a) | 5'(1 << c), 7'($urandom), $urandom_range(6, 12), 2);
             end
             seg(5'(1 << j), 7'($urandom), $urandom_range(6, 16), $urandom_range(1, 3));
           end
        default: begin
          for (int j = 0; j < pos; j++) seg(5'(1 << j), 7'($urandom), $urandom_range(6, 16), 2);
          enable = 1'b0;
          repeat (4) step();
          m_exp = 0;
          enable = 1'b1;
          step();
          for (int j = pos; j < 5; j++) seg(5'(1 << j), 7'($urandom), $urandom_range(6, 16), 2);
        end
      endcase
      verify($sformatf("rand%0d_k%0d", b, kind));
    end

`ifdef CAPTURA_TIMEOUT_EN
    clean_frame(1);
    verify("pre_timeout");
    check("sem_sinal_active_scan", 32'(sem_sinal), 0);
    repeat (110) step();
    check("sem_sinal_timeout", 32'(sem_sinal), 1);
    seg(5'b00001, 7'h01, 20, 2);
    check("sem_sinal_resume", 32'(sem_sinal), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
